// File: rtl/mux2_arb_pkg.sv
// Shared state encodings and defaults for the two-requester arbiter.
// No timing of its own; holds no flow-control behaviour.
package mux2_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT0 = 2'b01,
    GRANT1 = 2'b10
  } arb_state_t;

  localparam int unsigned MAX_HOLD_DEFAULT = 8;
  localparam int          HOLD_CNT_W       = 8;

  // Maps a requester index onto its grant state.
  function automatic arb_state_t grant_state(input logic idx);
    return idx ? GRANT1 : GRANT0;
  endfunction

endpackage

// File: rtl/mux2_arbiter_if.sv
// Requester/arbiter bundle: requests and data in, grants, select and shared data out.
// Pure wiring; grants are the only flow control, requesters hold req until done.
interface mux2_arbiter_if;

  logic req_0;
  logic req_1;
  logic data_0;
  logic data_1;
  logic grant_0;
  logic grant_1;
  logic sel;
  logic data_out;
  logic busy;

  modport master (
    output req_0, req_1, data_0, data_1,
    input  grant_0, grant_1, sel, data_out, busy
  );

  modport slave (
    input  req_0, req_1, data_0, data_1,
    output grant_0, grant_1, sel, data_out, busy
  );

endinterface

// File: rtl/nand_mux2.sv
// Four-NAND 2:1 mux: data_out = sel ? data_0 : data_1.
// Combinational, zero latency; no backpressure.
module nand_mux2 (
  input  logic sel,
  input  logic data_0,
  input  logic data_1,
  output logic data_out
);

  logic sel_n;
  logic leg_0_n;
  logic leg_1_n;

  assign sel_n    = ~(sel & sel);
  assign leg_0_n  = ~(data_0 & sel);
  assign leg_1_n  = ~(data_1 & sel_n);
  assign data_out = ~(leg_0_n & leg_1_n);

endmodule

// File: rtl/mux2_arbiter.sv
// Round-robin 2:1 arbiter + NAND mux; grant 1 cycle after request, data_out 0 latency.
// No backpressure: requesters hold req; MUX2_ARB_PREEMPT_EN adds MAX_HOLD-cycle preemption.
module mux2_arbiter
  import mux2_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input logic           clk,
  input logic           rst,
  mux2_arbiter_if.slave bus
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_max_hold_range
    $error("mux2_arbiter: MAX_HOLD must be in 2..255");
  end

  arb_state_t state;
  arb_state_t state_nxt;
  logic       last_served;
  logic       sel_q;
  logic       grant_0_q;
  logic       grant_1_q;
  logic       busy_q;
  logic       enter_grant;
  logic       hold_expired;
  logic       data_out_w;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A waiting requester takes over directly, without an IDLE bubble.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (bus.req_0 && bus.req_1) begin
          state_nxt = grant_state(~last_served);
        end else if (bus.req_0) begin
          state_nxt = GRANT0;
        end else if (bus.req_1) begin
          state_nxt = GRANT1;
        end
      end
      GRANT0: begin
        if (bus.req_1 && (!bus.req_0 || hold_expired)) begin
          state_nxt = GRANT1;
        end else if (!bus.req_0) begin
          state_nxt = IDLE;
        end
      end
      GRANT1: begin
        if (bus.req_0 && (!bus.req_1 || hold_expired)) begin
          state_nxt = GRANT0;
        end else if (!bus.req_1) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign enter_grant = (state_nxt != IDLE) && (state_nxt != state);

  // Outputs are registered from state_nxt so they line up with the state flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_0_q   <= 1'b0;
      grant_1_q   <= 1'b0;
      busy_q      <= 1'b0;
      sel_q       <= 1'b0;
      last_served <= 1'b1;
    end else begin
      grant_0_q <= (state_nxt == GRANT0);
      grant_1_q <= (state_nxt == GRANT1);
      busy_q    <= (state_nxt != IDLE);
      if (enter_grant) begin
        last_served <= (state_nxt == GRANT1);
        sel_q       <= (state_nxt == GRANT0);
      end
    end
  end

`ifdef MUX2_ARB_PREEMPT_EN
  logic [HOLD_CNT_W-1:0] hold_cnt;
  logic                  other_waiting;

  assign other_waiting = ((state == GRANT0) && bus.req_1) ||
                         ((state == GRANT1) && bus.req_0);
  assign hold_expired  = (hold_cnt == HOLD_CNT_W'(MAX_HOLD - 1));

  // Counts only cycles in which the other side is kept waiting; saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if (enter_grant) begin
      hold_cnt <= '0;
    end else if (other_waiting && (hold_cnt != '1)) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end
`else
  assign hold_expired = 1'b0;
`endif

  nand_mux2 u_out_mux (
    .sel      (sel_q),
    .data_0   (bus.data_0),
    .data_1   (bus.data_1),
    .data_out (data_out_w)
  );

  assign bus.grant_0  = grant_0_q;
  assign bus.grant_1  = grant_1_q;
  assign bus.busy     = busy_q;
  assign bus.sel      = sel_q;
  assign bus.data_out = data_out_w;

endmodule
